icache_responder: RTL and testbench

//  Direct-mapped, one-word-per-frame instruction cache on the cache end of the datapath cache interface.
//  - Answers the datapath instruction fetch (imemREN/imemaddr) with ihit/imemload.
//  - Refills misses from the memory controller over the iREN/iaddr/iwait/iload handshake.
//  - Sits between the pipelined datapath fetch stage and the memory controller; read-only.

---
 rtl/icache_responder.sv | 123 ++++++++++++
 tb/tb_icache_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-frame instruction cache. It answers datapath fetches
// combinationally on a hit and refills misses from the memory controller.
module icache_responder #(
  parameter int SETS   = 16,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  input  logic              flush,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = WORD_W - IDX_W - 2;

  typedef enum logic {IDLE, FETCH} state_e;

  state_e            state_q, state_d;
  logic [SETS-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [TAG_W-1:0]  tag_d  [SETS];
  logic [WORD_W-1:0] data_q [SETS];
  logic [WORD_W-1:0] data_d [SETS];
  logic [WORD_W-1:0] miss_addr_q, miss_addr_d;
  logic [31:0]       hit_cnt_q, hit_cnt_d;
  logic [31:0]       miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]  req_idx, miss_idx;
  logic [TAG_W-1:0]  req_tag, miss_tag;
  logic              hit;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign req_idx  = imemaddr[IDX_W+1:2];
  assign req_tag  = imemaddr[WORD_W-1:IDX_W+2];
  assign miss_idx = miss_addr_q[IDX_W+1:2];
  assign miss_tag = miss_addr_q[WORD_W-1:IDX_W+2];

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    miss_addr_d = miss_addr_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    hit         = 1'b0;
    ihit        = 1'b0;
    imemload    = '0;
    iREN        = 1'b0;
    iaddr       = '0;

    case (state_q)
      IDLE: begin
        // A flush cycle never reports a hit, even for a frame that is still valid.
        hit  = imemREN & ~flush & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
        ihit = hit;
        if (hit) begin
          imemload  = data_q[req_idx];
          hit_cnt_d = sat_inc(hit_cnt_q);
        end
        if (flush) valid_d = '0;
        if (imemREN && !hit) begin
          // Byte-offset bits are masked, the refill is always word aligned.
          miss_addr_d = {imemaddr[WORD_W-1:2], imemaddr[1:0] & 2'b00};
          miss_cnt_d  = sat_inc(miss_cnt_q);
          state_d     = FETCH;
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = miss_addr_q;
        if (flush) valid_d = '0;
        // The refill completes into the latched frame even if the fetch was squashed;
        // a concurrent flush loses to the fill for that one frame.
        if (!iwait) begin
          valid_d[miss_idx] = 1'b1;
          tag_d[miss_idx]   = miss_tag;
          data_d[miss_idx]  = iload;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      miss_addr_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      miss_addr_q <= miss_addr_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Tag and data storage carry no reset; the valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: a per-cycle vector table plus hand-written
// sequences for reset and the multi-cycle reset-during-refill case.
module tb_icache_responder;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  icache_responder #(.SETS(16), .WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        fl;
    logic        iw;
    logic [31:0] ild;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_ren;
    logic [31:0] e_iaddr;
    logic [31:0] e_hc;
    logic [31:0] e_mc;
  } vec_t;

  vec_t vq[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic ren, input logic [31:0] addr, input logic fl,
                     input logic iw, input logic [31:0] ild, input logic e_hit,
                     input logic [31:0] e_load, input logic e_ren,
                     input logic [31:0] e_iaddr, input int e_hc, input int e_mc);
    vec_t v;
    v.ren = ren; v.addr = addr; v.fl = fl; v.iw = iw; v.ild = ild;
    v.e_hit = e_hit; v.e_load = e_load; v.e_ren = e_ren; v.e_iaddr = e_iaddr;
    v.e_hc = 32'(e_hc); v.e_mc = 32'(e_mc);
    vq.push_back(v);
  endtask

  initial begin
    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; flush = 1'b0; iwait = 1'b1; iload = '0;

    //   ren addr   fl iw iload         hit load          iREN iaddr  hc mc
    // cold miss on 0x0 with two wait cycles, then hit
    add(1, 32'h0,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0,  0, 0);
    add(1, 32'h0,  0, 1, 32'h0,        0, 32'h0,        1, 32'h0,  0, 1);
    add(1, 32'h0,  0, 1, 32'h0,        0, 32'h0,        1, 32'h0,  0, 1);
    add(1, 32'h0,  0, 0, 32'h2001000A, 0, 32'h0,        1, 32'h0,  0, 1);
    add(1, 32'h0,  0, 1, 32'h0,        1, 32'h2001000A, 0, 32'h0,  0, 1);
    // conflict: 0x40 evicts 0x0, then 0x0 refills and hits twice
    add(1, 32'h40, 0, 1, 32'h0,        0, 32'h0,        0, 32'h0,  1, 1);
    add(1, 32'h40, 0, 0, 32'hAAAA0040, 0, 32'h0,        1, 32'h40, 1, 2);
    add(1, 32'h0,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0,  1, 2);
    add(1, 32'h0,  0, 0, 32'h2001000A, 0, 32'h0,        1, 32'h0,  1, 3);
    add(1, 32'h0,  0, 1, 32'h0,        1, 32'h2001000A, 0, 32'h0,  1, 3);
    add(1, 32'h0,  0, 1, 32'h0,        1, 32'h2001000A, 0, 32'h0,  2, 3);
    // squash: address moves to 0xC during the 0x8 refill
    add(1, 32'h8,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0,  3, 3);
    add(1, 32'hC,  0, 1, 32'h0,        0, 32'h0,        1, 32'h8,  3, 4);
    add(1, 32'hC,  0, 0, 32'h00000808, 0, 32'h0,        1, 32'h8,  3, 4);
    add(1, 32'hC,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0,  3, 4);
    add(1, 32'hC,  0, 0, 32'h00000C0C, 0, 32'h0,        1, 32'hC,  3, 5);
    add(1, 32'h8,  0, 1, 32'h0,        1, 32'h00000808, 0, 32'h0,  3, 5);
    add(1, 32'hC,  0, 1, 32'h0,        1, 32'h00000C0C, 0, 32'h0,  4, 5);
    // cache 0x4, flush in IDLE, then 0x4 misses again
    add(1, 32'h4,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0,  5, 5);
    add(1, 32'h4,  0, 0, 32'h44444444, 0, 32'h0,        1, 32'h4,  5, 6);
    add(1, 32'h4,  0, 1, 32'h0,        1, 32'h44444444, 0, 32'h0,  5, 6);
    add(0, 32'h4,  1, 1, 32'h0,        0, 32'h0,        0, 32'h0,  6, 6);
    add(1, 32'h0,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0,  6, 6);
    add(1, 32'h0,  0, 0, 32'h2001000A, 0, 32'h0,        1, 32'h0,  6, 7);
    add(1, 32'h0,  0, 1, 32'h0,        1, 32'h2001000A, 0, 32'h0,  6, 7);
    add(1, 32'h4,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0,  7, 7);
    // FETCH ignores a request to the valid 0x0; flush during the fill keeps frame 1 only
    add(1, 32'h0,  0, 1, 32'h0,        0, 32'h0,        1, 32'h4,  7, 8);
    add(1, 32'h4,  1, 0, 32'h55555555, 0, 32'h0,        1, 32'h4,  7, 8);
    add(1, 32'h4,  0, 1, 32'h0,        1, 32'h55555555, 0, 32'h0,  7, 8);
    add(1, 32'h0,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0,  8, 8);
    add(1, 32'h0,  0, 0, 32'h2001000A, 0, 32'h0,        1, 32'h0,  8, 9);
    // byte offset bits are ignored
    add(1, 32'h6,  0, 1, 32'h0,        1, 32'h55555555, 0, 32'h0,  8, 9);
    // idle: no requests, counters frozen
    for (int i = 0; i < 10; i++)
      add(0, 32'(i * 4), 0, i[0], 32'h0, 0, 32'h0, 0, 32'h0, 9, 9);

    // reset state
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_ihit", 0, 32'(ihit), 32'h0);
    chk("rst_load", 0, imemload, 32'h0);
    chk("rst_iREN", 0, 32'(iREN), 32'h0);
    chk("rst_iaddr", 0, iaddr, 32'h0);
    chk("rst_hc", 0, hit_cnt, 32'h0);
    chk("rst_mc", 0, miss_cnt, 32'h0);
    nRST = 1'b1;

    foreach (vq[i]) begin
      @(negedge CLK);
      imemREN = vq[i].ren; imemaddr = vq[i].addr; flush = vq[i].fl;
      iwait = vq[i].iw; iload = vq[i].ild;
      #1;
      chk("ihit", i, 32'(ihit), 32'(vq[i].e_hit));
      chk("imemload", i, imemload, vq[i].e_load);
      chk("iREN", i, 32'(iREN), 32'(vq[i].e_ren));
      chk("iaddr", i, iaddr, vq[i].e_iaddr);
      chk("hit_cnt", i, hit_cnt, vq[i].e_hc);
      chk("miss_cnt", i, miss_cnt, vq[i].e_mc);
    end

    // reset while a refill is stalled
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = 32'h100; flush = 1'b0; iwait = 1'b1; iload = 32'hDEADBEEF;
    #1;
    chk("r5_miss", 0, 32'(ihit), 32'h0);
    @(negedge CLK);
    #1;
    chk("r5_iREN", 0, 32'(iREN), 32'h1);
    chk("r5_iaddr", 0, iaddr, 32'h100);
    chk("r5_mc", 0, miss_cnt, 32'd10);
    nRST = 1'b0;
    #1;
    chk("r5_iREN_rst", 0, 32'(iREN), 32'h0);
    chk("r5_iaddr_rst", 0, iaddr, 32'h0);
    chk("r5_hc_rst", 0, hit_cnt, 32'h0);
    chk("r5_mc_rst", 0, miss_cnt, 32'h0);
    @(negedge CLK);
    nRST = 1'b1; iwait = 1'b0;
    #1;
    chk("r5_post_100", 0, 32'(ihit), 32'h0);
    imemaddr = 32'h0;
    #1;
    chk("r5_post_0", 0, 32'(ihit), 32'h0);
    @(negedge CLK);
    iload = 32'hCAFE0000;
    #1;
    chk("r5_refill_iREN", 0, 32'(iREN), 32'h1);
    chk("r5_refill_iaddr", 0, iaddr, 32'h0);
    chk("r5_refill_mc", 0, miss_cnt, 32'h1);
    @(negedge CLK);
    #1;
    chk("r5_hit", 0, 32'(ihit), 32'h1);
    chk("r5_hit_load", 0, imemload, 32'hCAFE0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
